// File: rtl/data_check.sv
// Checks a 512-bit AXI-Stream of replicated, incrementing 16-bit words and TLAST placement.
// Optional upstream-hold exercise: define DATA_CHECK_BACKPRESSURE_EN for LFSR-driven TREADY.
module data_check #(
  parameter int          PACKET_BEATS  = 4,
  parameter logic [15:0] FIRST_VALUE   = 16'h0001,
  parameter bit          STOP_ON_ERROR = 1'b0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [511:0] AXIS_TDATA,
  input  logic         AXIS_TVALID,
  input  logic         AXIS_TLAST,
  output logic         AXIS_TREADY,
  input  logic         clear,
  output logic [31:0]  beat_count,
  output logic [31:0]  packet_count,
  output logic [15:0]  data_errors,
  output logic [15:0]  last_errors,
  output logic         error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_tready;
  logic        w_tready_nxt;
  logic [15:0] r_expected;
  logic [7:0]  r_pos;
  logic [31:0] r_beat_count;
  logic [31:0] r_packet_count;
  logic [15:0] r_data_errors;
  logic [15:0] r_last_errors;
  logic        r_error;

  logic        w_accept;
  logic [15:0] w_lane0;
  logic        w_lane_mis;
  logic        w_data_err;
  logic        w_pos_end;
  logic        w_last_err;
  logic        w_any_err;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_accept  = AXIS_TVALID & r_tready;
  assign w_lane0   = AXIS_TDATA[15:0];
  assign w_pos_end = (r_pos == 8'(PACKET_BEATS));

  always_comb begin
    w_lane_mis = 1'b0;
    for (int i = 1; i < 32; i++) begin
      if (AXIS_TDATA[16*i +: 16] != w_lane0) w_lane_mis = 1'b1;
    end
  end

  assign w_data_err = w_lane_mis | (w_lane0 != r_expected);
  assign w_last_err = (AXIS_TLAST != w_pos_end);
  assign w_any_err  = w_data_err | w_last_err;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  w_state_nxt = S_RUN;
      S_RUN: begin
        // A beat accepted while clear is high records no error, so it cannot fault.
        if (STOP_ON_ERROR && w_accept && w_any_err && !clear) w_state_nxt = S_FAULT;
      end
      S_FAULT: if (clear) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef DATA_CHECK_BACKPRESSURE_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_lfsr <= 16'hACE1;
    else         r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
  end

  assign w_tready_nxt = (w_state_nxt == S_RUN) & (r_lfsr[0] | r_lfsr[1]);
`else
  assign w_tready_nxt = (w_state_nxt == S_RUN);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_tready <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tready <= w_tready_nxt;
    end
  end

  // Tracking resyncs to the received data so a single bad beat costs one error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_expected <= FIRST_VALUE;
      r_pos      <= 8'd1;
    end else if (w_accept) begin
      r_expected <= w_lane0 + 16'd1;
      r_pos      <= (AXIS_TLAST || w_pos_end) ? 8'd1 : r_pos + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_beat_count   <= '0;
      r_packet_count <= '0;
      r_data_errors  <= '0;
      r_last_errors  <= '0;
      r_error        <= 1'b0;
    end else if (clear) begin
      r_beat_count   <= '0;
      r_packet_count <= '0;
      r_data_errors  <= '0;
      r_last_errors  <= '0;
      r_error        <= 1'b0;
    end else if (w_accept) begin
      r_beat_count <= sat_inc32(r_beat_count);
      if (AXIS_TLAST) r_packet_count <= sat_inc32(r_packet_count);
      if (w_data_err) r_data_errors  <= sat_inc16(r_data_errors);
      if (w_last_err) r_last_errors  <= sat_inc16(r_last_errors);
      if (w_any_err)  r_error        <= 1'b1;
    end
  end

  assign AXIS_TREADY  = r_tready;
  assign beat_count   = r_beat_count;
  assign packet_count = r_packet_count;
  assign data_errors  = r_data_errors;
  assign last_errors  = r_last_errors;
  assign error        = r_error;

endmodule

// File: tb/tb_data_check.sv
// Directed bench for data_check: three instances (default, FIRST_VALUE=FFFE, STOP_ON_ERROR=1) share one stimulus stream.
module tb_data_check;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [511:0] tdata = '0;
  logic         tvalid = 1'b0;
  logic         tlast = 1'b0;
  logic         clear = 1'b0;

  logic        m_tready, w_tready, s_tready;
  logic [31:0] m_beat, m_pkt, w_beat, w_pkt, s_beat, s_pkt;
  logic [15:0] m_derr, m_lerr, w_derr, w_lerr, s_derr, s_lerr;
  logic        m_err, w_err, s_err;

  int n_cmp = 0;
  int n_bad = 0;
  int lowseen = 0;

`ifdef DATA_CHECK_BACKPRESSURE_EN
  localparam int N_CLEAN = 1000;
`else
  localparam int N_CLEAN = 400;
`endif

  always #5 clk = ~clk;

  data_check u_main (
    .clk(clk), .resetn(resetn), .AXIS_TDATA(tdata), .AXIS_TVALID(tvalid), .AXIS_TLAST(tlast),
    .AXIS_TREADY(m_tready), .clear(clear), .beat_count(m_beat), .packet_count(m_pkt),
    .data_errors(m_derr), .last_errors(m_lerr), .error(m_err)
  );

  data_check #(.FIRST_VALUE(16'hFFFE)) u_wrap (
    .clk(clk), .resetn(resetn), .AXIS_TDATA(tdata), .AXIS_TVALID(tvalid), .AXIS_TLAST(tlast),
    .AXIS_TREADY(w_tready), .clear(clear), .beat_count(w_beat), .packet_count(w_pkt),
    .data_errors(w_derr), .last_errors(w_lerr), .error(w_err)
  );

  data_check #(.STOP_ON_ERROR(1'b1)) u_stop (
    .clk(clk), .resetn(resetn), .AXIS_TDATA(tdata), .AXIS_TVALID(tvalid), .AXIS_TLAST(tlast),
    .AXIS_TREADY(s_tready), .clear(clear), .beat_count(s_beat), .packet_count(s_pkt),
    .data_errors(s_derr), .last_errors(s_lerr), .error(s_err)
  );

  task automatic do_reset();
    tvalid = 1'b0;
    tlast  = 1'b0;
    clear  = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and holds it until u_main takes it (bounded).
  task automatic send(input logic [15:0] w, input logic last, input int bad_lane, input logic [15:0] bad_val);
    logic seen;
    int   n;
    for (int i = 0; i < 32; i++) tdata[16*i +: 16] = (i == bad_lane) ? bad_val : w;
    tvalid = 1'b1;
    tlast  = last;
    seen   = 1'b0;
    n      = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      seen = m_tready;
      if (!seen) lowseen++;
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL handshake: beat %h not accepted within %0d cycles (required accept)", w, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    send(16'd1, 1'b0, -1, 16'h0);
    send(16'd2, 1'b0, -1, 16'h0);
    tvalid = 1'b0;
    #3 resetn = 1'b0;
    #1;
    n_cmp++; if (m_beat !== 32'd0) begin n_bad++; $display("FAIL async_reset_beat: got %0d want 0", m_beat); end
    n_cmp++; if ({m_tready, w_tready, s_tready} !== 3'b000) begin n_bad++; $display("FAIL reset_tready: got %b want 000", {m_tready, w_tready, s_tready}); end
    n_cmp++; if ({m_pkt, m_derr, m_lerr, m_err} !== 65'd0) begin n_bad++; $display("FAIL reset_counters: got %h want 0", {m_pkt, m_derr, m_lerr, m_err}); end
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    #1;
    n_cmp++; if (m_tready !== 1'b0) begin n_bad++; $display("FAIL tready_idle: got %b want 0", m_tready); end
    @(posedge clk);
    #1;
    n_cmp++; if (m_tready !== 1'b1) begin n_bad++; $display("FAIL tready_run: got %b want 1", m_tready); end
    send(16'd1, 1'b0, -1, 16'h0);
    n_cmp++; if (m_beat !== 32'd1) begin n_bad++; $display("FAIL first_beat_count: got %0d want 1", m_beat); end
    n_cmp++; if (m_derr !== 16'd0) begin n_bad++; $display("FAIL restart_value: got %0d data errors want 0", m_derr); end
    tvalid = 1'b0;
  endtask

  task automatic test_clean_stream();
    do_reset();
    lowseen = 0;
    for (int i = 1; i <= N_CLEAN; i++) send(16'(i), (i % 4) == 0, -1, 16'h0);
    tvalid = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (m_beat !== 32'(N_CLEAN)) begin n_bad++; $display("FAIL clean_beats: got %0d want %0d", m_beat, N_CLEAN); end
    n_cmp++; if (m_pkt !== 32'(N_CLEAN / 4)) begin n_bad++; $display("FAIL clean_packets: got %0d want %0d", m_pkt, N_CLEAN / 4); end
    n_cmp++; if ({m_derr, m_lerr} !== 32'd0) begin n_bad++; $display("FAIL clean_errcounts: got %0d/%0d want 0/0", m_derr, m_lerr); end
    n_cmp++; if (m_err !== 1'b0) begin n_bad++; $display("FAIL clean_flag: got %b want 0", m_err); end
`ifdef DATA_CHECK_BACKPRESSURE_EN
    n_cmp++; if (lowseen == 0) begin n_bad++; $display("FAIL backpressure_seen: got %0d stalls want >0", lowseen); end
`else
    n_cmp++; if (lowseen != 0) begin n_bad++; $display("FAIL no_backpressure: got %0d stalls want 0", lowseen); end
`endif
  endtask

  task automatic test_data_error();
    do_reset();
    for (int i = 1; i <= 9; i++) send(16'(i), (i % 4) == 0, -1, 16'h0);
    n_cmp++; if (m_err !== 1'b0) begin n_bad++; $display("FAIL derr_pre_flag: got %b want 0", m_err); end
    send(16'd10, 1'b0, 7, 16'hBEEF);
    n_cmp++; if (m_derr !== 16'd1) begin n_bad++; $display("FAIL derr_count: got %0d want 1", m_derr); end
    n_cmp++; if (m_lerr !== 16'd0) begin n_bad++; $display("FAIL derr_lastcount: got %0d want 0", m_lerr); end
    n_cmp++; if (m_err !== 1'b1) begin n_bad++; $display("FAIL derr_flag: got %b want 1", m_err); end
    send(16'd11, 1'b0, -1, 16'h0);
    send(16'd12, 1'b1, -1, 16'h0);
    tvalid = 1'b0;
    n_cmp++; if (m_derr !== 16'd1) begin n_bad++; $display("FAIL derr_no_cascade: got %0d want 1", m_derr); end
    n_cmp++; if (m_err !== 1'b1) begin n_bad++; $display("FAIL derr_sticky: got %b want 1", m_err); end
  endtask

  task automatic test_tlast_error();
    do_reset();
    for (int i = 1; i <= 7; i++) send(16'(i), i == 4, -1, 16'h0);
    send(16'd8, 1'b0, -1, 16'h0);
    n_cmp++; if (m_lerr !== 16'd1) begin n_bad++; $display("FAIL lerr_count: got %0d want 1", m_lerr); end
    for (int i = 9; i <= 12; i++) send(16'(i), i == 12, -1, 16'h0);
    tvalid = 1'b0;
    n_cmp++; if (m_lerr !== 16'd1) begin n_bad++; $display("FAIL lerr_realign: got %0d want 1", m_lerr); end
    n_cmp++; if (m_derr !== 16'd0) begin n_bad++; $display("FAIL lerr_data: got %0d want 0", m_derr); end
    n_cmp++; if (m_pkt !== 32'd2) begin n_bad++; $display("FAIL lerr_packets: got %0d want 2", m_pkt); end
  endtask

  task automatic test_wrap();
    do_reset();
    send(16'hFFFE, 1'b0, -1, 16'h0);
    send(16'hFFFF, 1'b0, -1, 16'h0);
    send(16'h0000, 1'b0, -1, 16'h0);
    send(16'h0001, 1'b1, -1, 16'h0);
    tvalid = 1'b0;
    n_cmp++; if (w_beat !== 32'd4) begin n_bad++; $display("FAIL wrap_beats: got %0d want 4", w_beat); end
    n_cmp++; if ({w_derr, w_lerr} !== 32'd0) begin n_bad++; $display("FAIL wrap_errors: got %0d/%0d want 0/0", w_derr, w_lerr); end
    n_cmp++; if ({w_pkt, w_err} !== 33'd2) begin n_bad++; $display("FAIL wrap_pkt_flag: got %0d/%b want 1/0", w_pkt, w_err); end
    n_cmp++; if (m_derr !== 16'd1) begin n_bad++; $display("FAIL resync_from_ffff: got %0d want 1", m_derr); end
  endtask

  task automatic test_stop_on_error();
    int n;
    do_reset();
    for (int i = 1; i <= 4; i++) send(16'(i), i == 4, -1, 16'h0);
    send(16'd5, 1'b0, 3, 16'h0000);
    n_cmp++; if (s_tready !== 1'b0) begin n_bad++; $display("FAIL stop_tready: got %b want 0", s_tready); end
    n_cmp++; if (s_beat !== 32'd5) begin n_bad++; $display("FAIL stop_beats: got %0d want 5", s_beat); end
    n_cmp++; if ({s_derr, s_lerr, s_err} !== {16'd1, 16'd0, 1'b1}) begin n_bad++; $display("FAIL stop_errs: got %0d/%0d/%b want 1/0/1", s_derr, s_lerr, s_err); end
    send(16'd6, 1'b0, -1, 16'h0);
    tvalid = 1'b0;
    n_cmp++; if ({s_beat, s_pkt} !== {32'd5, 32'd1}) begin n_bad++; $display("FAIL stop_parked: got %0d/%0d want 5/1", s_beat, s_pkt); end
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    n_cmp++; if ({s_beat, s_derr, s_err} !== 49'd0) begin n_bad++; $display("FAIL stop_clear: got %0d/%0d/%b want 0/0/0", s_beat, s_derr, s_err); end
    n = 0;
    while (s_tready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++; if (s_tready !== 1'b1) begin n_bad++; $display("FAIL stop_resume: got %b want 1", s_tready); end
  endtask

  task automatic test_clear_accept();
    do_reset();
    for (int i = 1; i <= 3; i++) send(16'(i), 1'b0, -1, 16'h0);
    clear = 1'b1;
    send(16'd4, 1'b1, -1, 16'h0);
    clear = 1'b0;
    n_cmp++; if ({m_beat, m_pkt, m_err} !== 65'd0) begin n_bad++; $display("FAIL clear_wins: got %0d/%0d/%b want 0/0/0", m_beat, m_pkt, m_err); end
    send(16'd5, 1'b0, -1, 16'h0);
    tvalid = 1'b0;
    n_cmp++; if (m_beat !== 32'd1) begin n_bad++; $display("FAIL post_clear_beat: got %0d want 1", m_beat); end
    n_cmp++; if ({m_derr, m_lerr} !== 32'd0) begin n_bad++; $display("FAIL post_clear_track: got %0d/%0d want 0/0", m_derr, m_lerr); end
  endtask

  initial begin
    test_reset();
    test_clean_stream();
    test_data_error();
    test_tlast_error();
    test_wrap();
    test_stop_on_error();
    test_clear_accept();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_check.md
# data_check

Stream checker directly downstream of the 512-bit AXI-Stream test-pattern source. It consumes beats, verifies each beat is the same 16-bit word replicated across all 32 lanes and incrementing by one per beat, and verifies TLAST lands on every PACKET_BEATS-th beat. It reports saturating beat, packet and error counts plus a sticky error flag to the control/status logic of the PCIe base design.

## Interface
- PACKET_BEATS, 4, beats per packet; legal range 1..255.
- FIRST_VALUE, 16'h0001, 16-bit word expected on the first beat after reset.
- STOP_ON_ERROR, 0, if 1 the first detected error parks the FSM in FAULT.
- clk  in  1  sole clock.
- resetn  in  1  asynchronous, active-low reset.
- AXIS_TDATA  in  512  stream data; lane i = bits [16i+15:16i].
- AXIS_TVALID  in  1  source has a beat.
- AXIS_TLAST  in  1  last beat of a packet.
- AXIS_TREADY  out  1  checker accepts the beat.
- clear  in  1  synchronous pulse: zero counters and flag, leave FAULT.
- beat_count  out  32  accepted beats, saturating.
- packet_count  out  32  accepted beats with TLAST=1, saturating.
- data_errors  out  16  beats failing the data check, saturating.
- last_errors  out  16  beats failing the TLAST check, saturating.
- error  out  1  sticky: any error since reset/clear.

## Operation
- Accept = AXIS_TVALID & AXIS_TREADY on a rising clk edge.
- Internal: expected (16 b), pos (8 b, 1..PACKET_BEATS), state.
- Reset values: AXIS_TREADY=0, all counters 0, error=0, expected=FIRST_VALUE, pos=1, state=IDLE.
- States:
  - IDLE: TREADY=0; unconditionally -> RUN next cycle.
  - RUN: TREADY driven per Configuration; checks every accepted beat.
  - FAULT: TREADY=0; only clear exits, -> RUN.
- Data check on accept: fail if any lane != lane 0, or lane 0 != expected. One failure counts once per beat regardless of lane count.
- TLAST check on accept: fail if AXIS_TLAST != (pos == PACKET_BEATS).
- After every accepted beat: expected <= lane0 + 1 (mod 2^16; resyncs to data, so one bad beat gives one error, not a cascade). pos <= 1 if AXIS_TLAST else pos+1; if pos==PACKET_BEATS and TLAST=0, pos <= 1 (re-align on both).
- 16'hFFFF followed by 16'h0000 is correct wrap, not an error.
- Counters saturate at all-ones; they never wrap.
- error sets on any data or TLAST failure; clears only on reset or clear.
- STOP_ON_ERROR=1: the failing beat is still counted, then RUN -> FAULT.
- clear and accept in same cycle: clear wins for counters/flag (beat not counted, no error recorded); expected and pos still update from that beat.
- resetn low mid-packet: all state returns to reset values immediately (asynchronously); the partial packet is not recovered.

## Timing
- All outputs registered; no combinational path from any input to any output.
- AXIS_TREADY first high 2 cycles after resetn deasserts (IDLE, then RUN).
- AXIS_TREADY never depends on AXIS_TVALID in the same cycle.
- Counters and error reflect an accepted beat on the cycle after the accepting edge.
- FAULT: TREADY low on the cycle after the failing beat is accepted.
- Throughput: one beat per clock when TREADY is held high.

## Configuration
- DATA_CHECK_BACKPRESSURE_EN defined: in RUN, TREADY <= lfsr[0] | lfsr[1] from a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 at reset). The LFSR advances every cycle, giving ~75% ready duty, to exercise upstream hold behaviour.
- Not defined: TREADY=1 throughout RUN; no LFSR logic.

## Test plan
- Clean stream 1,2,3,... with TLAST every 4th beat, 400 beats -> beat_count=400, packet_count=100, both error counts 0, error=0.
- Beat 10 lane 7 = 16'hBEEF, rest correct -> data_errors=1, last_errors=0, error=1 one cycle after beat 10; beat 11 checks clean.
- TLAST missing on beat 8 -> last_errors=1, pos re-aligns, beats 9-12 with TLAST on 12 -> no further errors.
- Stream starting at 16'hFFFE after setting FIRST_VALUE=16'hFFFE -> FFFE,FFFF,0000,0001 all pass, data_errors=0.
- STOP_ON_ERROR=1, bad beat 5 -> TREADY low from next cycle, beat_count=5; pulse clear -> counters 0, error=0, TREADY high again.
- With DATA_CHECK_BACKPRESSURE_EN: source holds TDATA/TLAST while stalled, 1000 beats -> zero errors, and TREADY low observed at least once.
